addroundkey_serial: RTL and testbench

- Round-key addition stage sitting directly downstream of the column-mix stage in the AES datapath; consumes its 128-bit state and start/ready handshake.
- Captures the state and the current round key, then XORs them one column per cycle over 4 cycles, matching the word-serial cadence of the column-mix stage.
- Also maintains the AES round counter (up for encrypt, down for decrypt) and flags the final round, so the top-level sequencer does not need a separate counter.

---
 rtl/addroundkey_serial.sv | 168 ++++++++++++++++
 tb/tb_addroundkey_serial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/addroundkey_serial.sv
// ---------------------------------------------------------------------------
// addroundkey_serial
//   AES round-key addition stage, word-serial. A start captures the 128-bit
//   state and round key. The key is then XORed in one column per cycle over
//   four cycles, and the result is presented one cycle after the last column.
//   The block also keeps the AES round counter: it counts up for encrypt and
//   down for decrypt, and it flags the final round for the sequencer.
//
//   Ports
//     clk, rst_n        clock (rising edge), async active-low reset
//     data_in, key_in   128-bit state / round key, row-major byte packing:
//                       byte(r,c) = [127-32r-8c -: 8]
//     start_in          request; data_in/key_in/en_de sampled with it
//     en_de             1 = encrypt (count up), 0 = decrypt (count down)
//     round_rst_in      synchronous reload of the round counter
//     data_out          result state, held until the next completion
//     ready_out         one-cycle pulse when data_out is newly valid
//     busy_out          high while a transform is in flight
//     round_out         current round index
//     last_round_out    round_out is the final round for the direction
// ---------------------------------------------------------------------------

// One state column XOR one key column (four bytes, rows 0..3 MSB first).
module addroundkey_col (
    input  logic [31:0] st_col,
    input  logic [31:0] key_col,
    output logic [31:0] res_col
);
    assign res_col = st_col ^ key_col;
endmodule

module addroundkey_serial #(
    parameter int NUM_ROUNDS = 10,
    parameter int RND_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [127:0]       data_in,
    input  logic [127:0]       key_in,
    input  logic               start_in,
    input  logic               en_de,
    input  logic               round_rst_in,
    output logic [127:0]       data_out,
    output logic               ready_out,
    output logic               busy_out,
    output logic [RND_W-1:0]   round_out,
    output logic               last_round_out
);
    localparam int                NUM_COLS = 4;
    localparam logic [RND_W-1:0]  LAST_RND = RND_W'(NUM_ROUNDS);

    // Low two bits of the COLx encodings are the column index.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        COL0 = 3'b100,
        COL1 = 3'b101,
        COL2 = 3'b110,
        COL3 = 3'b111
    } state_t;

    state_t       state;
    logic [127:0] st_q, key_q, work_q;
    logic         dir_q;
    // Set on the edge that leaves COL3. The outputs load one edge later, so
    // the start-to-ready latency is five edges and COL3's column is already
    // in work_q when it is copied out.
    logic         done_q;
    logic [1:0]   col_idx;

    logic [NUM_COLS-1:0][31:0] st_col, key_col, res_col;

    assign col_idx = state[1:0];

    // Per-column lanes. The columns are gathered out of the row-major packing.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign st_col[c][8*(3-r) +: 8]  = st_q[127-32*r-8*c -: 8];
            assign key_col[c][8*(3-r) +: 8] = key_q[127-32*r-8*c -: 8];
        end
        addroundkey_col u_col (
            .st_col  (st_col[c]),
            .key_col (key_col[c]),
            .res_col (res_col[c])
        );
    end

    // Next round value. A reload wins over a coincident completion and takes
    // the live en_de. A completion uses the direction captured at start.
    logic [RND_W-1:0] round_nxt;
    logic             dir_nxt, last_nxt, round_upd;

    always_comb begin
        round_nxt = round_out;
        dir_nxt   = dir_q;
        round_upd = 1'b0;
        if (round_rst_in) begin
            round_upd = 1'b1;
            dir_nxt   = en_de;
            round_nxt = en_de ? '0 : LAST_RND;
        end else if (done_q) begin
            round_upd = 1'b1;
            if (dir_q)
                round_nxt = (round_out == LAST_RND) ? '0 : round_out + 1'b1;
            else
                round_nxt = (round_out == '0) ? LAST_RND : round_out - 1'b1;
        end
        last_nxt = dir_nxt ? (round_nxt == LAST_RND) : (round_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            st_q           <= '0;
            key_q          <= '0;
            work_q         <= '0;
            dir_q          <= 1'b0;
            done_q         <= 1'b0;
            data_out       <= '0;
            ready_out      <= 1'b0;
            busy_out       <= 1'b0;
            round_out      <= '0;
            last_round_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            done_q    <= 1'b0;

            case (state)
                IDLE: begin
                    // While done_q is pending the job is still busy, so a
                    // start in that cycle is ignored.
                    if (start_in && !done_q) begin
                        st_q     <= data_in;
                        key_q    <= key_in;
                        dir_q    <= en_de;
                        busy_out <= 1'b1;
                        state    <= COL0;
                    end
                end
                COL0, COL1, COL2, COL3: begin
                    for (int r = 0; r < 4; r++)
                        work_q[127-32*r-8*int'(col_idx) -: 8]
                            <= res_col[col_idx][8*(3-r) +: 8];
                    case (state)
                        COL0:    state <= COL1;
                        COL1:    state <= COL2;
                        COL2:    state <= COL3;
                        default: begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase

            if (done_q) begin
                data_out  <= work_q;
                ready_out <= 1'b1;
                busy_out  <= 1'b0;
            end

            if (round_upd) begin
                round_out      <= round_nxt;
                last_round_out <= last_nxt;
            end
        end
    end
endmodule

// File: tb/tb_addroundkey_serial.sv
// Testbench for addroundkey_serial. It uses a scoreboard queue that is filled
// when a job is issued and drained by a monitor on every ready_out pulse.
module tb_addroundkey_serial;
    localparam int NR = 10;
    localparam int RW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [127:0]   data_in = '0, key_in = '0;
    logic           start_in = 1'b0, en_de = 1'b1, round_rst_in = 1'b0;
    logic [127:0]   data_out;
    logic           ready_out, busy_out, last_round_out;
    logic [RW-1:0]  round_out;

    addroundkey_serial #(.NUM_ROUNDS(NR), .RND_W(RW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .key_in         (key_in),
        .start_in       (start_in),
        .en_de          (en_de),
        .round_rst_in   (round_rst_in),
        .data_out       (data_out),
        .ready_out      (ready_out),
        .busy_out       (busy_out),
        .round_out      (round_out),
        .last_round_out (last_round_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, ready_cnt = 0;

    typedef struct {
        logic [127:0]  d;
        logic [RW-1:0] r;
        logic          l;
    } exp_t;
    exp_t sb[$];

    // Reference round counter, kept as a plain integer.
    int m_round = 0;
    bit m_last  = 1'b0;

    function automatic void m_complete(input bit dir);
        if (dir) m_round = (m_round == NR) ? 0 : m_round + 1;
        else     m_round = (m_round == 0) ? NR : m_round - 1;
        m_last = dir ? (m_round == NR) : (m_round == 0);
    endfunction

    function automatic void m_reload(input bit dir);
        m_round = dir ? 0 : NR;
        m_last  = dir ? (m_round == NR) : (m_round == 0);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ready_out) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready data_out=%h", data_out);
            end else begin
                e = sb.pop_front();
                chk("data_out", data_out, e.d);
                chk("round_out", 128'(round_out), 128'(e.r));
                chk("last_round_out", 128'(last_round_out), 128'(e.l));
            end
        end
    end

    // noise: extra start pulses sampled during COL1 and COL3.
    // rr: round_rst_in sampled on the completion edge.
    task automatic run_job(input logic [127:0] d, input logic [127:0] k,
                           input bit dir, input bit noise, input bit rr);
        int n;
        int rc0;
        rc0 = ready_cnt;
        @(posedge clk); #1;
        data_in = d; key_in = k; en_de = dir; start_in = 1'b1;
        if (rr) m_reload(dir); else m_complete(dir);
        sb.push_back('{d ^ k, RW'(m_round), m_last});
        @(posedge clk); #1;                 // start edge T is behind us
        start_in = 1'b0;
        data_in = rnd128(); key_in = rnd128();
        for (n = 1; n <= 10; n++) begin
            if (noise) start_in = (n == 2) || (n == 4);
            if (rr) round_rst_in = (n == 5);
            @(posedge clk); #1;
            start_in = 1'b0; round_rst_in = 1'b0;
            if (ready_out) break;
            chk("busy_in_flight", 128'(busy_out), 128'd1);
        end
        chk("latency", 128'(n), 128'd5);
        chk("busy_after", 128'(busy_out), 128'd0);
        repeat (noise ? 8 : 3) @(posedge clk);
        #1;
        chk("ready_pulse_count", 128'(ready_cnt - rc0), 128'd1);
    endtask

    task automatic reload(input bit dir);
        @(posedge clk); #1;
        en_de = dir; round_rst_in = 1'b1;
        @(posedge clk); #1;
        round_rst_in = 1'b0;
        m_reload(dir);
        chk("reload_round", 128'(round_out), 128'(m_round));
        chk("reload_last", 128'(last_round_out), 128'(m_last));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, '0);
        chk("rst_ready", 128'(ready_out), 128'd0);
        chk("rst_busy", 128'(busy_out), 128'd0);
        chk("rst_round", 128'(round_out), 128'd0);
        chk("rst_last", 128'(last_round_out), 128'd0);
        @(negedge clk); rst_n = 1'b1;

        // Zero state: result is the key itself; round 0 -> 1
        run_job('0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, 1'b0);
        chk("tp1_key_passthru", data_out, 128'h000102030405060708090a0b0c0d0e0f);

        // Known vector, both directions
        run_job(128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, 1'b0);
        chk("tp2_vec_enc", data_out, 128'h00102030405060708090a0b0c0d0e0f0);
        run_job(128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 1'b0);
        chk("tp2_vec_dec", data_out, 128'h00102030405060708090a0b0c0d0e0f0);

        // Starts while busy and during COL3 are ignored
        run_job(rnd128(), rnd128(), 1'b1, 1'b1, 1'b0);

        // Full encrypt sweep with wrap, then decrypt sweep with wrap
        reload(1'b1);
        for (int i = 0; i < NR + 1; i++) begin
            run_job(rnd128(), rnd128(), 1'b1, 1'b0, 1'b0);
            if (i == NR - 1) chk("enc_last_flag", 128'(last_round_out), 128'd1);
        end
        reload(1'b0);
        for (int i = 0; i < NR + 1; i++) begin
            run_job(rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
            if (i == NR - 1) chk("dec_last_flag", 128'(last_round_out), 128'd1);
        end

        // Reset during COL2 aborts the job
        rc0 = ready_cnt;
        @(posedge clk); #1;
        data_in = rnd128(); key_in = rnd128(); en_de = 1'b1; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_data_out", data_out, '0);
        chk("abort_ready", 128'(ready_out), 128'd0);
        chk("abort_busy", 128'(busy_out), 128'd0);
        chk("abort_round", 128'(round_out), 128'd0);
        chk("abort_last", 128'(last_round_out), 128'd0);
        m_round = 0; m_last = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_ready", 128'(ready_cnt - rc0), 128'd0);
        run_job(rnd128(), rnd128(), 1'b1, 1'b0, 1'b0);

        // Reload coincident with completion wins
        run_job(rnd128(), rnd128(), 1'b1, 1'b0, 1'b0);
        run_job(rnd128(), rnd128(), 1'b1, 1'b0, 1'b1);
        run_job(rnd128(), rnd128(), 1'b0, 1'b0, 1'b1);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
